// File: rtl/seven_segment_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module : seven_segment_scan_controller_pkg
// Brief  : Shared constants and width helper for the 7-segment scan controller.
// Rev    : 1.0
// ============================================================================
package seven_segment_scan_controller_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_segment_scan_controller_scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : scan_tick_gen
// Brief  : Slot counter and digit index; exposes next-cycle values and frame wrap.
// Rev    : 1.0
// ============================================================================
module scan_tick_gen #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int CNT_W       = 10,
    parameter int IDX_W       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] o_cnt_nxt,
    output logic [IDX_W-1:0] o_idx_nxt,
    output logic             o_frame_wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_slot_wrap;

    assign w_slot_wrap  = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign o_frame_wrap = w_slot_wrap && (r_idx == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        o_cnt_nxt = r_cnt + CNT_W'(1);
        o_idx_nxt = r_idx;
        if (w_slot_wrap) begin
            o_cnt_nxt = '0;
            o_idx_nxt = o_frame_wrap ? '0 : r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= o_cnt_nxt;
            r_idx <= o_idx_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seven_segment_scan_controller.sv
`default_nettype none
// ============================================================================
// Module : seven_segment_scan_controller
// Brief  : Multiplexed 7-segment scanner with tear-free frame buffer and blanking.
// Rev    : 1.0
// ============================================================================
module seven_segment_scan_controller
    import seven_segment_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 8,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic                    ready,
    output logic [3:0]              digit_bcd,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int CNT_W = width_of(REFRESH_DIV);
    localparam int IDX_W = width_of(NUM_DIGITS);

    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic                    w_frame_wrap;

    logic [4*NUM_DIGITS-1:0] r_pending;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic                    r_pending_valid;

    logic [4*NUM_DIGITS-1:0] w_active_nxt;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic                    w_show;
    logic [3:0]              w_bcd_nxt;
    logic [NUM_DIGITS-1:0]   w_sel_nxt;

    scan_tick_gen #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W),
        .IDX_W       (IDX_W)
    ) u_tick (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_cnt_nxt    (w_cnt_nxt),
        .o_idx_nxt    (w_idx_nxt),
        .o_frame_wrap (w_frame_wrap)
    );

    assign ready = !r_pending_valid;

    // Outputs are registered from next-cycle state so they line up with cnt/idx.
    assign w_active_nxt = (w_frame_wrap && r_pending_valid) ? r_pending : r_active;

    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        w_lz_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run && (w_active_nxt[4*k +: 4] == 4'h0);
            w_lz_mask[k] = zero_run && (LZ_BLANK != 0);
        end
    end

    always_comb begin
        w_show    = (int'(w_cnt_nxt) >= BLANK_CYCLES);
        w_sel_nxt = '0;
        w_bcd_nxt = BLANK_CODE;
        if (w_show) begin
            w_sel_nxt = NUM_DIGITS'(1) << w_idx_nxt;
            if (!w_lz_mask[w_idx_nxt]) begin
                w_bcd_nxt = w_active_nxt[4*int'(w_idx_nxt) +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending       <= '0;
            r_active        <= {NUM_DIGITS{BLANK_CODE}};
            r_pending_valid <= 1'b0;
            digit_sel       <= '0;
            digit_bcd       <= BLANK_CODE;
            frame_done      <= 1'b0;
        end else begin
            r_active   <= w_active_nxt;
            digit_sel  <= w_sel_nxt;
            digit_bcd  <= w_bcd_nxt;
            frame_done <= w_frame_wrap;
            if (load && !r_pending_valid) begin
                r_pending       <= bcd_in;
                r_pending_valid <= 1'b1;
            end else if (w_frame_wrap) begin
                r_pending_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_seven_segment_scan_controller
// Brief  : Directed self-checking bench for the 7-segment scan controller.
// Rev    : 1.0
// ============================================================================
module tb_seven_segment_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        ready;
    logic [3:0]  digit_bcd;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    seven_segment_scan_controller #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (10),
        .BLANK_CYCLES (2),
        .LZ_BLANK     (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .ready      (ready),
        .digit_bcd  (digit_bcd),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Leaves the DUT in its reset state; that cycle is numbered 0.
    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic load_at(input int c, input logic [15:0] v);
        run_to(c);
        load   = 1'b1;
        bcd_in = v;
        step();
        load   = 1'b0;
    endtask

    task automatic expect_at(input int c, input logic [3:0] sel, input logic [3:0] bcd);
        run_to(c);
        check("digit_sel", digit_sel, sel);
        check("digit_bcd", digit_bcd, bcd);
    endtask

    initial begin
        // Reset state, blank first frame, and a 1234 frame loaded at cycle 5
        do_reset();
        check("rst_ready", ready, 1'b1);
        check("rst_frame_done", frame_done, 1'b0);
        for (int c = 0; c < 12; c++) begin
            run_to(c);
            check("scan_sel", digit_sel, (c >= 2 && c <= 9) ? 4'b0001 : 4'b0000);
            check("scan_bcd", digit_bcd, 4'hF);
            if (c == 5) begin
                check("ready_before_load", ready, 1'b1);
                load   = 1'b1;
                bcd_in = 16'h1234;
            end
            if (c == 6) begin
                load = 1'b0;
                check("ready_after_load", ready, 1'b0);
            end
        end
        expect_at(22, 4'b0100, 4'hF);
        run_to(39);
        check("fd_39", frame_done, 1'b0);
        check("ready_39", ready, 1'b0);
        run_to(40);
        check("fd_40", frame_done, 1'b1);
        check("ready_40", ready, 1'b1);
        expect_at(40, 4'b0000, 4'hF);
        run_to(41);
        check("fd_41", frame_done, 1'b0);
        for (int c = 42; c < 50; c++) expect_at(c, 4'b0001, 4'h4);
        expect_at(52, 4'b0010, 4'h3);
        expect_at(62, 4'b0100, 4'h2);
        expect_at(71, 4'b0000, 4'hF);
        for (int c = 72; c < 80; c++) expect_at(c, 4'b1000, 4'h1);
        run_to(80);
        check("fd_80", frame_done, 1'b1);

        // Leading-zero blanking
        do_reset();
        load_at(5, 16'h0070);
        expect_at(42, 4'b0001, 4'h0);
        expect_at(52, 4'b0010, 4'h7);
        expect_at(62, 4'b0100, 4'hF);
        expect_at(72, 4'b1000, 4'hF);
        load_at(45, 16'h0000);
        expect_at(82, 4'b0001, 4'h0);
        expect_at(92, 4'b0010, 4'hF);
        expect_at(102, 4'b0100, 4'hF);
        expect_at(112, 4'b1000, 4'hF);

        // Held load while pending is full
        do_reset();
        run_to(5);
        load   = 1'b1;
        bcd_in = 16'h4321;
        step();
        bcd_in = 16'h5678;
        run_to(39);
        check("hold_ready_39", ready, 1'b0);
        run_to(40);
        check("hold_ready_40", ready, 1'b1);
        step();
        load = 1'b0;
        check("hold_ready_41", ready, 1'b0);
        expect_at(42, 4'b0001, 4'h1);
        expect_at(79, 4'b1000, 4'h4);
        expect_at(80, 4'b0000, 4'hF);
        expect_at(82, 4'b0001, 4'h8);
        expect_at(112, 4'b1000, 4'h5);

        // Mid-frame reset discards the pending frame
        do_reset();
        load_at(5, 16'h1234);
        expect_at(23, 4'b0100, 4'hF);
        check("pre_rst_ready", ready, 1'b0);
        rst_n = 1'b0;
        step();
        check("mid_rst_sel", digit_sel, 4'b0000);
        check("mid_rst_bcd", digit_bcd, 4'hF);
        check("mid_rst_ready", ready, 1'b1);
        rst_n = 1'b1;
        cyc   = 0;
        run_to(40);
        check("post_rst_fd", frame_done, 1'b1);
        expect_at(42, 4'b0001, 4'hF);
        expect_at(52, 4'b0010, 4'hF);
        expect_at(62, 4'b0100, 4'hF);
        expect_at(72, 4'b1000, 4'hF);

        // A..E codes pass through and stop leading-zero suppression
        do_reset();
        load_at(5, 16'hA905);
        expect_at(42, 4'b0001, 4'h5);
        expect_at(52, 4'b0010, 4'h0);
        expect_at(62, 4'b0100, 4'h9);
        expect_at(72, 4'b1000, 4'hA);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
